result_unload: RTL and testbench

//  Serializes one wide result vector from the PE array into a stream of WORD_W-bit words.

---
 rtl/result_unload_pkg.sv | 19 +
 rtl/result_unload.sv | 104 ++++++++++
 tb/tb_result_unload.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/result_unload_pkg.sv
// Shared types and constants for the result unloader.
// The header word layout is built here so RTL and docs agree on one definition.
package result_unload_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam logic [7:0] HDR_MAGIC   = 8'hA5;
  localparam int         FRAME_CNT_W = 16;

  function automatic logic [31:0] hdr_word(input logic [7:0] num_words,
                                           input logic [FRAME_CNT_W-1:0] cnt);
    return {HDR_MAGIC, num_words, cnt};
  endfunction

endpackage

// File: rtl/result_unload.sv
// Serializes one wide PE-array result into a ready/valid stream of WORD_W-bit words, word 0 first.
// Optional header word before each frame when RESULT_UNLOAD_HDR_EN is defined.
module result_unload
  import result_unload_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_WORDS*WORD_W-1:0]   res_data_i,
  input  logic                          res_valid_i,
  output logic                          res_ready_o,
  output logic [WORD_W-1:0]             data_o,
  output logic                          data_valid_o,
  input  logic                          data_ready_i,
  output logic                          data_last_o,
  output logic                          busy_o,
  output logic [FRAME_CNT_W-1:0]        frame_cnt_o
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t                        state_q, state_d;
  logic [NUM_WORDS*WORD_W-1:0]   buf_q;
  logic [IDX_W-1:0]              idx_q;
  logic [FRAME_CNT_W-1:0]        cnt_q;
  logic                          ready_q;
  logic                          capture;
  logic                          word_xfer;
  logic                          frame_done;

  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    word_xfer  = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (res_valid_i && ready_q) begin
          capture = 1'b1;
`ifdef RESULT_UNLOAD_HDR_EN
          state_d = HDR;
`else
          state_d = SEND;
`endif
        end
      end
      HDR: begin
        if (data_ready_i) state_d = SEND;
      end
      SEND: begin
        if (data_ready_i) begin
          word_xfer = 1'b1;
          if (idx_q == LAST_IDX) begin
            frame_done = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ready is registered from the next state so upstream never sees a comb path from data_ready_i
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE);
      if (capture) begin
        buf_q <= res_data_i;
        idx_q <= '0;
      end else if (word_xfer) begin
        idx_q <= frame_done ? '0 : idx_q + 1'b1;
      end
      if (frame_done) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    data_o       = '0;
    data_valid_o = (state_q != IDLE);
    data_last_o  = (state_q == SEND) && (idx_q == LAST_IDX);
    case (state_q)
      SEND: data_o = buf_q[WORD_W*32'(idx_q) +: WORD_W];
`ifdef RESULT_UNLOAD_HDR_EN
      HDR:  data_o = WORD_W'(hdr_word(8'(NUM_WORDS), cnt_q));
`endif
      default: data_o = '0;
    endcase
  end

  assign res_ready_o = ready_q;
  assign busy_o      = (state_q != IDLE);
  assign frame_cnt_o = cnt_q;

endmodule

// File: tb/tb_result_unload.sv
// Randomized bench for result_unload: a queue of expected words per frame is checked word by word.
// Build with +define+RESULT_UNLOAD_HDR_EN to exercise the header variant.
module tb_result_unload;
  localparam int W = 32;
  localparam int N = 8;
`ifdef RESULT_UNLOAD_HDR_EN
  localparam int HOFS = 1;
`else
  localparam int HOFS = 0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] res_data;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   data;
  logic           data_valid;
  logic           data_ready;
  logic           data_last;
  logic           busy;
  logic [15:0]    frame_cnt;

  int n_chk = 0;
  int n_err = 0;
  int model_cnt = 0;

  result_unload #(.WORD_W(W), .NUM_WORDS(N)) dut (
    .clk(clk), .rst(rst),
    .res_data_i(res_data), .res_valid_i(res_valid), .res_ready_o(res_ready),
    .data_o(data), .data_valid_o(data_valid), .data_ready_i(data_ready),
    .data_last_o(data_last), .busy_o(busy), .frame_cnt_o(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(res_ready), 32'd1);
    check({tag, "_valid"}, 32'(data_valid), 32'd0);
    check({tag, "_last"}, 32'(data_last), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_data"}, data, 32'd0);
    check({tag, "_cnt"}, 32'(frame_cnt), 32'(model_cnt));
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge.
  // stall_at: data word index held with ready low for 3 cycles (-1 none).
  // abort_after: number of data words sent before a reset pulse (-1 none).
  task automatic send_frame(input logic [31:0] w [N], input int ready_pct,
                            input int stall_at, input int abort_after);
    logic [31:0] exp[$];
    int k = 0;
    int cyc = 0;
    int stalls = 0;
    for (int i = 0; i < N; i++) res_data[i*W +: W] = w[i];
`ifdef RESULT_UNLOAD_HDR_EN
    exp.push_back({8'hA5, 8'(N), 16'(model_cnt)});
`endif
    for (int i = 0; i < N; i++) exp.push_back(w[i]);
    check("res_ready_pre", 32'(res_ready), 32'd1);
    res_valid = 1'b1;
    @(negedge clk);
    while (k < exp.size()) begin
      if (abort_after >= 0 && k == abort_after + HOFS) begin
        rst = 1'b1;
        #1;
        check_idle("abort");
        @(negedge clk);
        rst = 1'b0;
        data_ready = 1'b0;
        res_valid = 1'b0;
        return;
      end
      // junk on the input side while sending must not be captured
      res_valid = 1'($urandom_range(1));
      res_data  = {N{$urandom()}};
      check("valid", 32'(data_valid), 32'd1);
      check("word", data, exp[k]);
      check("last", 32'(data_last), 32'(k == exp.size() - 1));
      check("busy", 32'(busy), 32'd1);
      check("res_ready_busy", 32'(res_ready), 32'd0);
      if (stall_at >= 0 && k == stall_at + HOFS && stalls < 3) begin
        data_ready = 1'b0;
        stalls++;
      end else begin
        data_ready = ($urandom_range(99) < 32'(ready_pct));
      end
      @(posedge clk);
      if (data_ready) k++;
      cyc++;
      @(negedge clk);
      if (cyc > 200) begin
        check("timeout", 32'(k), 32'(exp.size()));
        break;
      end
    end
    res_valid  = 1'b0;
    data_ready = 1'b0;
    model_cnt  = (model_cnt + 1) & 16'hFFFF;
    if (ready_pct == 100 && stall_at < 0) check("cycles", 32'(cyc), 32'(exp.size()));
    if (stall_at >= 0) check("stalls", 32'(stalls), 32'd3);
    check_idle("post");
  endtask

  logic [31:0] fw [N];

  initial begin
    rst = 1'b1;
    res_valid = 1'b0;
    res_data = '0;
    data_ready = 1'b0;
    #100;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset");

    for (int i = 0; i < N; i++) fw[i] = 32'(10 + i);
    send_frame(fw, 100, -1, -1);
    send_frame(fw, 100, 2, -1);
    // reset mid-frame drops the frame and the counter
    model_cnt = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_frame(fw, 100, -1, 4);
    @(negedge clk);
    check_idle("after_abort");
    for (int i = 0; i < N; i++) fw[i] = 32'(20 + i);
    send_frame(fw, 100, -1, -1);

    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++) fw[i] = $urandom();
      send_frame(fw, 60, -1, -1);
    end

    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    model_cnt = 16'hFFFF;
    @(negedge clk);
    for (int i = 0; i < N; i++) fw[i] = $urandom();
    send_frame(fw, 80, -1, -1);
    check("wrap", 32'(frame_cnt), 32'd0);
    send_frame(fw, 100, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
